// File: rtl/interrupt_pkg.sv
// Shared types and fixed vector addresses for the 8227 interrupt entry sequencer.
package interrupt_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DUMMY1   = 3'd1,
    DUMMY2   = 3'd2,
    PUSH_PCH = 3'd3,
    PUSH_PCL = 3'd4,
    PUSH_P   = 3'd5,
    VEC_LO   = 3'd6,
    VEC_HI   = 3'd7
  } intStep_t;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    NMI   = 2'd1,
    IRQ   = 2'd2,
    BRK   = 2'd3
  } intKind_t;

  localparam logic [15:0] VECTOR_NMI   = 16'hFFFA;
  localparam logic [15:0] VECTOR_RESET = 16'hFFFC;
  localparam logic [15:0] VECTOR_IRQ   = 16'hFFFE;

endpackage

// File: rtl/nmi_edge_detector.sv
// Latches a rising edge on the NMI pin until the sequencer commits to the NMI vector.
module nmi_edge_detector (
  input  logic clk,
  input  logic nrst,
  input  logic nmiIn,
  input  logic clear,
  output logic pending
);

  logic nmiPrev;

  // History resets high so a pin already high out of reset is not an event.
  // A new edge wins over a same-cycle clear so it is never dropped.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nmiPrev <= 1'b1;
      pending <= 1'b0;
    end else begin
      nmiPrev <= nmiIn;
      if (nmiIn && !nmiPrev)
        pending <= 1'b1;
      else if (clear)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Arbitrates reset/NMI/IRQ/BRK and steps the seven-cycle interrupt entry,
// decoding per-cycle datapath strobes from the registered state.
module interrupt_sequencer
  import interrupt_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        nonMaskableInterrupt,
  input  logic        interruptRequest,
  input  logic        interruptDisable,
  input  logic        instructionBoundary,
  input  logic        breakRequest,
  output logic        sequenceActive,
  output logic [2:0]  interruptStep,
  output logic        pushPCH,
  output logic        pushPCL,
  output logic        pushStatus,
  output logic        suppressWrite,
  output logic        loadVectorLow,
  output logic        loadVectorHigh,
  output logic [15:0] vectorAddress,
  output logic        breakFlagValue,
  output logic        setInterruptDisable,
  output logic        nmiPending
);

  intStep_t    state;
  intKind_t    kind;
  logic [15:0] vecBase;
  logic        irqTaken;
  logic        nmiClear;

  assign irqTaken = interruptRequest && !interruptDisable;
  // Pending NMI is consumed only when the vector actually latched is FFFA.
  assign nmiClear = (state == PUSH_P) && (kind != RESET) && nmiPending;

  nmi_edge_detector uNmiEdge (
    .clk     (clk),
    .nrst    (nrst),
    .nmiIn   (nonMaskableInterrupt),
    .clear   (nmiClear),
    .pending (nmiPending)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= DUMMY1;
      kind    <= RESET;
      vecBase <= VECTOR_RESET;
    end else begin
      unique case (state)
        IDLE: begin
          if (instructionBoundary && nmiPending) begin
            kind  <= NMI;
            state <= DUMMY1;
          end else if (instructionBoundary && irqTaken) begin
            kind  <= IRQ;
            state <= DUMMY1;
          end else if (breakRequest) begin
            // BRK already spent its fetch cycle, so it skips the first dummy.
            kind  <= BRK;
            state <= DUMMY2;
          end
        end
        DUMMY1:   state <= DUMMY2;
        DUMMY2:   state <= PUSH_PCH;
        PUSH_PCH: state <= PUSH_PCL;
        PUSH_PCL: state <= PUSH_P;
        PUSH_P: begin
          state <= VEC_LO;
          // Late NMI hijacks an IRQ/BRK entry up to this point.
          if (kind == RESET)   vecBase <= VECTOR_RESET;
          else if (nmiPending) vecBase <= VECTOR_NMI;
          else                 vecBase <= VECTOR_IRQ;
        end
        VEC_LO:   state <= VEC_HI;
        VEC_HI:   state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign sequenceActive      = (state != IDLE);
  assign interruptStep       = state;
  assign pushPCH             = (state == PUSH_PCH);
  assign pushPCL             = (state == PUSH_PCL);
  assign pushStatus          = (state == PUSH_P);
  assign suppressWrite       = (kind == RESET) && (state != IDLE);
  assign loadVectorLow       = (state == VEC_LO);
  assign loadVectorHigh      = (state == VEC_HI);
  assign vectorAddress       = (state == VEC_HI) ? vecBase + 16'd1 : vecBase;
  assign breakFlagValue      = (state == PUSH_P) && (kind == BRK);
  assign setInterruptDisable = (state == VEC_LO);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench: each scenario queues the entry it expects, then compares it
// against what the sequencer produces up to loadVectorHigh.
module tb_interrupt_sequencer;
  import interrupt_pkg::*;

  logic        tb_clk = 1'b0;
  logic        nrst = 1'b0;
  logic        nonMaskableInterrupt = 1'b0;
  logic        interruptRequest = 1'b0;
  logic        interruptDisable = 1'b1;
  logic        instructionBoundary = 1'b0;
  logic        breakRequest = 1'b0;
  logic        sequenceActive;
  logic [2:0]  interruptStep;
  logic        pushPCH, pushPCL, pushStatus, suppressWrite;
  logic        loadVectorLow, loadVectorHigh;
  logic [15:0] vectorAddress;
  logic        breakFlagValue, setInterruptDisable, nmiPending;

  int testsRun = 0;
  int failCount = 0;

  typedef struct packed {
    logic [15:0] vecLo;
    logic [15:0] vecHi;
    logic        bflag;
    int          suppressCnt;
    int          pchAt;
    int          hiAt;
  } exp_t;

  typedef struct packed {
    logic [15:0] vecLo;
    logic [15:0] vecHi;
    logic        bflag;
    logic        sid;
    logic        timeout;
    int          suppressCnt;
    int          pchAt;
    int          hiAt;
  } obs_t;

  exp_t sbQ[$];

  always #5 tb_clk = ~tb_clk;

  interrupt_sequencer dut (
    .clk                  (tb_clk),
    .nrst                 (nrst),
    .nonMaskableInterrupt (nonMaskableInterrupt),
    .interruptRequest     (interruptRequest),
    .interruptDisable     (interruptDisable),
    .instructionBoundary  (instructionBoundary),
    .breakRequest         (breakRequest),
    .sequenceActive       (sequenceActive),
    .interruptStep        (interruptStep),
    .pushPCH              (pushPCH),
    .pushPCL              (pushPCL),
    .pushStatus           (pushStatus),
    .suppressWrite        (suppressWrite),
    .loadVectorLow        (loadVectorLow),
    .loadVectorHigh       (loadVectorHigh),
    .vectorAddress        (vectorAddress),
    .breakFlagValue       (breakFlagValue),
    .setInterruptDisable  (setInterruptDisable),
    .nmiPending           (nmiPending)
  );

  // Observes one entry up to loadVectorHigh; cycle stamps are counted from the
  // cycle 'offset' negedges before the call. Optionally raises NMI at a given step.
  task automatic waitSeq(input int offset, input bit doNmi, input logic [2:0] nmiStep,
                         output obs_t o);
    o = '0;
    o.timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge tb_clk);
      if (doNmi && interruptStep == nmiStep) nonMaskableInterrupt = 1'b1;
      if (pushPCH && o.pchAt == 0) o.pchAt = i + 1 + offset;
      if (suppressWrite && (pushPCH || pushPCL || pushStatus)) o.suppressCnt++;
      if (pushStatus) o.bflag = breakFlagValue;
      if (loadVectorLow) begin
        o.vecLo = vectorAddress;
        o.sid   = setInterruptDisable;
      end
      if (loadVectorHigh) begin
        o.vecHi   = vectorAddress;
        o.hiAt    = i + 1 + offset;
        o.timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    obs_t o;
    exp_t e;
    repeat (2) @(negedge tb_clk);
    testsRun++;
    if (interruptStep !== 3'd1) begin failCount++; $display("FAIL reset_step got %0d want 1", interruptStep); end
    testsRun++;
    if (sequenceActive !== 1'b1 || suppressWrite !== 1'b1) begin
      failCount++; $display("FAIL reset_active got act=%b sup=%b want 1 1", sequenceActive, suppressWrite);
    end
    testsRun++;
    if (vectorAddress !== 16'hFFFC) begin failCount++; $display("FAIL reset_vector got %h want fffc", vectorAddress); end
    testsRun++;
    if ({pushPCH, pushPCL, pushStatus, loadVectorLow, loadVectorHigh, setInterruptDisable, breakFlagValue, nmiPending} !== 8'h00) begin
      failCount++; $display("FAIL reset_strobes got %b want 00000000",
        {pushPCH, pushPCL, pushStatus, loadVectorLow, loadVectorHigh, setInterruptDisable, breakFlagValue, nmiPending});
    end
    nrst = 1'b1;
    sbQ.push_back('{vecLo:16'hFFFC, vecHi:16'hFFFD, bflag:1'b0, suppressCnt:3, pchAt:0, hiAt:0});
    waitSeq(0, 1'b0, 3'd0, o);
    e = sbQ.pop_front();
    testsRun++;
    if (o.timeout) begin failCount++; $display("FAIL reset_seq_timeout got timeout want loadVectorHigh"); end
    testsRun++;
    if (o.vecLo !== e.vecLo || o.vecHi !== e.vecHi) begin
      failCount++; $display("FAIL reset_seq_vec got %h/%h want %h/%h", o.vecLo, o.vecHi, e.vecLo, e.vecHi);
    end
    testsRun++;
    if (o.suppressCnt != e.suppressCnt) begin
      failCount++; $display("FAIL reset_seq_suppress got %0d want %0d", o.suppressCnt, e.suppressCnt);
    end
    @(negedge tb_clk);
    testsRun++;
    if (interruptStep !== 3'd0) begin failCount++; $display("FAIL reset_seq_idle got %0d want 0", interruptStep); end
  endtask

  task automatic test_irq_mask();
    obs_t o;
    exp_t e;
    @(negedge tb_clk);
    interruptRequest = 1'b1; interruptDisable = 1'b1; instructionBoundary = 1'b1;
    @(negedge tb_clk);
    instructionBoundary = 1'b0;
    for (int k = 0; k < 2; k++) begin
      testsRun++;
      if (sequenceActive !== 1'b0) begin failCount++; $display("FAIL irq_masked_idle got %b want 0", sequenceActive); end
      @(negedge tb_clk);
    end
    interruptDisable = 1'b0; instructionBoundary = 1'b1;
    sbQ.push_back('{vecLo:16'hFFFE, vecHi:16'hFFFF, bflag:1'b0, suppressCnt:0, pchAt:3, hiAt:7});
    @(negedge tb_clk);
    instructionBoundary = 1'b0; interruptRequest = 1'b0;
    waitSeq(1, 1'b0, 3'd0, o);
    e = sbQ.pop_front();
    testsRun++;
    if (o.vecLo !== e.vecLo || o.vecHi !== e.vecHi) begin
      failCount++; $display("FAIL irq_vec got %h/%h want %h/%h", o.vecLo, o.vecHi, e.vecLo, e.vecHi);
    end
    testsRun++;
    if (o.bflag !== e.bflag || o.suppressCnt != e.suppressCnt || o.sid !== 1'b1) begin
      failCount++; $display("FAIL irq_flags got b=%b sup=%0d sei=%b want b=%b sup=%0d sei=1",
        o.bflag, o.suppressCnt, o.sid, e.bflag, e.suppressCnt);
    end
    testsRun++;
    if (o.pchAt != e.pchAt || o.hiAt != e.hiAt) begin
      failCount++; $display("FAIL irq_timing got pch=%0d hi=%0d want pch=%0d hi=%0d", o.pchAt, o.hiAt, e.pchAt, e.hiAt);
    end
    interruptDisable = 1'b1;
  endtask

  task automatic test_nmi_held();
    obs_t o;
    exp_t e;
    @(negedge tb_clk);
    nonMaskableInterrupt = 1'b1;
    @(negedge tb_clk);
    testsRun++;
    if (nmiPending !== 1'b1) begin failCount++; $display("FAIL nmi_pending_set got %b want 1", nmiPending); end
    instructionBoundary = 1'b1;
    sbQ.push_back('{vecLo:16'hFFFA, vecHi:16'hFFFB, bflag:1'b0, suppressCnt:0, pchAt:3, hiAt:7});
    @(negedge tb_clk);
    instructionBoundary = 1'b0;
    waitSeq(1, 1'b0, 3'd0, o);
    e = sbQ.pop_front();
    testsRun++;
    if (o.vecLo !== e.vecLo || o.vecHi !== e.vecHi || o.hiAt != e.hiAt) begin
      failCount++; $display("FAIL nmi_vec got %h/%h at %0d want %h/%h at %0d", o.vecLo, o.vecHi, o.hiAt, e.vecLo, e.vecHi, e.hiAt);
    end
    for (int k = 0; k < 2; k++) begin
      repeat (3) @(negedge tb_clk);
      instructionBoundary = 1'b1;
      @(negedge tb_clk);
      instructionBoundary = 1'b0;
      testsRun++;
      if (sequenceActive !== 1'b0) begin failCount++; $display("FAIL nmi_held_retrigger got %b want 0", sequenceActive); end
    end
    repeat (2) @(negedge tb_clk);
    testsRun++;
    if (nmiPending !== 1'b0) begin failCount++; $display("FAIL nmi_held_pending got %b want 0", nmiPending); end
    nonMaskableInterrupt = 1'b0;
  endtask

  task automatic test_hijack();
    obs_t o;
    exp_t e;
    @(negedge tb_clk);
    interruptRequest = 1'b1; interruptDisable = 1'b0; instructionBoundary = 1'b1;
    sbQ.push_back('{vecLo:16'hFFFA, vecHi:16'hFFFB, bflag:1'b0, suppressCnt:0, pchAt:3, hiAt:7});
    @(negedge tb_clk);
    instructionBoundary = 1'b0; interruptRequest = 1'b0;
    waitSeq(1, 1'b1, PUSH_PCL, o);
    e = sbQ.pop_front();
    testsRun++;
    if (o.vecLo !== e.vecLo || o.vecHi !== e.vecHi) begin
      failCount++; $display("FAIL hijack_pcl_vec got %h/%h want %h/%h", o.vecLo, o.vecHi, e.vecLo, e.vecHi);
    end
    @(negedge tb_clk);
    testsRun++;
    if (nmiPending !== 1'b0) begin failCount++; $display("FAIL hijack_pcl_pending got %b want 0", nmiPending); end
    nonMaskableInterrupt = 1'b0;
    @(negedge tb_clk);
    interruptRequest = 1'b1; instructionBoundary = 1'b1;
    sbQ.push_back('{vecLo:16'hFFFE, vecHi:16'hFFFF, bflag:1'b0, suppressCnt:0, pchAt:3, hiAt:7});
    @(negedge tb_clk);
    instructionBoundary = 1'b0; interruptRequest = 1'b0;
    waitSeq(1, 1'b1, VEC_LO, o);
    e = sbQ.pop_front();
    testsRun++;
    if (o.vecLo !== e.vecLo || o.vecHi !== e.vecHi) begin
      failCount++; $display("FAIL late_nmi_irq_vec got %h/%h want %h/%h", o.vecLo, o.vecHi, e.vecLo, e.vecHi);
    end
    @(negedge tb_clk);
    testsRun++;
    if (nmiPending !== 1'b1 || interruptStep !== 3'd0) begin
      failCount++; $display("FAIL late_nmi_kept got pend=%b step=%0d want pend=1 step=0", nmiPending, interruptStep);
    end
    instructionBoundary = 1'b1;
    sbQ.push_back('{vecLo:16'hFFFA, vecHi:16'hFFFB, bflag:1'b0, suppressCnt:0, pchAt:3, hiAt:7});
    @(negedge tb_clk);
    instructionBoundary = 1'b0; nonMaskableInterrupt = 1'b0;
    waitSeq(1, 1'b0, 3'd0, o);
    e = sbQ.pop_front();
    testsRun++;
    if (o.vecLo !== e.vecLo || o.vecHi !== e.vecHi || o.pchAt != e.pchAt) begin
      failCount++; $display("FAIL late_nmi_followup got %h/%h pch=%0d want %h/%h pch=%0d",
        o.vecLo, o.vecHi, o.pchAt, e.vecLo, e.vecHi, e.pchAt);
    end
    @(negedge tb_clk);
    testsRun++;
    if (nmiPending !== 1'b0) begin failCount++; $display("FAIL late_nmi_cleared got %b want 0", nmiPending); end
    interruptDisable = 1'b1;
  endtask

  task automatic test_brk();
    obs_t o;
    exp_t e;
    @(negedge tb_clk);
    interruptRequest = 1'b1; interruptDisable = 1'b1;
    instructionBoundary = 1'b1; breakRequest = 1'b1;
    sbQ.push_back('{vecLo:16'hFFFE, vecHi:16'hFFFF, bflag:1'b1, suppressCnt:0, pchAt:2, hiAt:6});
    @(negedge tb_clk);
    instructionBoundary = 1'b0; breakRequest = 1'b0;
    testsRun++;
    if (interruptStep !== 3'd2) begin failCount++; $display("FAIL brk_entry_step got %0d want 2", interruptStep); end
    waitSeq(1, 1'b0, 3'd0, o);
    e = sbQ.pop_front();
    testsRun++;
    if (o.vecLo !== e.vecLo || o.vecHi !== e.vecHi || o.bflag !== e.bflag) begin
      failCount++; $display("FAIL brk_seq got %h/%h b=%b want %h/%h b=%b", o.vecLo, o.vecHi, o.bflag, e.vecLo, e.vecHi, e.bflag);
    end
    testsRun++;
    if (o.pchAt != e.pchAt || o.hiAt != e.hiAt) begin
      failCount++; $display("FAIL brk_timing got pch=%0d hi=%0d want pch=%0d hi=%0d", o.pchAt, o.hiAt, e.pchAt, e.hiAt);
    end
    // BRK arriving one cycle behind a taken IRQ boundary must not reshape it.
    @(negedge tb_clk);
    interruptDisable = 1'b0; instructionBoundary = 1'b1;
    sbQ.push_back('{vecLo:16'hFFFE, vecHi:16'hFFFF, bflag:1'b0, suppressCnt:0, pchAt:3, hiAt:7});
    @(negedge tb_clk);
    instructionBoundary = 1'b0; breakRequest = 1'b1; interruptRequest = 1'b0;
    @(negedge tb_clk);
    breakRequest = 1'b0;
    waitSeq(2, 1'b0, 3'd0, o);
    e = sbQ.pop_front();
    testsRun++;
    if (o.bflag !== e.bflag || o.pchAt != e.pchAt || o.hiAt != e.hiAt) begin
      failCount++; $display("FAIL b2b_brk_ignored got b=%b pch=%0d hi=%0d want b=%b pch=%0d hi=%0d",
        o.bflag, o.pchAt, o.hiAt, e.bflag, e.pchAt, e.hiAt);
    end
    @(negedge tb_clk);
    testsRun++;
    if (sequenceActive !== 1'b0) begin failCount++; $display("FAIL b2b_no_extra_seq got %b want 0", sequenceActive); end
    interruptDisable = 1'b1;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    exp_t e;
    bit found;
    found = 1'b0;
    @(negedge tb_clk);
    interruptRequest = 1'b1; interruptDisable = 1'b0; instructionBoundary = 1'b1;
    @(negedge tb_clk);
    instructionBoundary = 1'b0; interruptRequest = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge tb_clk);
      if (interruptStep == PUSH_PCH) nonMaskableInterrupt = 1'b1;
      if (interruptStep == PUSH_P) begin found = 1'b1; break; end
    end
    testsRun++;
    if (!found || nmiPending !== 1'b1) begin
      failCount++; $display("FAIL midreset_setup got found=%b pend=%b want 1 1", found, nmiPending);
    end
    nrst = 1'b0;
    #1;
    testsRun++;
    if (interruptStep !== 3'd1 || vectorAddress !== 16'hFFFC || pushStatus !== 1'b0) begin
      failCount++; $display("FAIL midreset_state got step=%0d vec=%h push=%b want 1 fffc 0", interruptStep, vectorAddress, pushStatus);
    end
    testsRun++;
    if (nmiPending !== 1'b0 || suppressWrite !== 1'b1) begin
      failCount++; $display("FAIL midreset_pending got pend=%b sup=%b want 0 1", nmiPending, suppressWrite);
    end
    @(negedge tb_clk);
    nrst = 1'b1;
    sbQ.push_back('{vecLo:16'hFFFC, vecHi:16'hFFFD, bflag:1'b0, suppressCnt:3, pchAt:0, hiAt:0});
    waitSeq(0, 1'b0, 3'd0, o);
    e = sbQ.pop_front();
    testsRun++;
    if (o.vecLo !== e.vecLo || o.vecHi !== e.vecHi || o.suppressCnt != e.suppressCnt) begin
      failCount++; $display("FAIL midreset_seq got %h/%h sup=%0d want %h/%h sup=%0d",
        o.vecLo, o.vecHi, o.suppressCnt, e.vecLo, e.vecHi, e.suppressCnt);
    end
    @(negedge tb_clk);
    testsRun++;
    if (nmiPending !== 1'b0) begin failCount++; $display("FAIL midreset_no_nmi got %b want 0", nmiPending); end
    nonMaskableInterrupt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_irq_mask();
    test_nmi_held();
    test_hijack();
    test_brk();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got no completion want summary");
    $fatal(1, "watchdog");
  end

endmodule
